// File: rtl/imem_fetch_if.sv
// Instruction-memory bus: program-load port, fetch handshake and fetch results.
// The master side (PC / loader) drives requests; the slave side is the memory.
interface imem_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // program-load port
  logic                  load_en;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  // fetch handshake
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  stall;

  // fetch results and load progress
  logic [DATA_WIDTH-1:0] instruction;
  logic                  inst_valid;
  logic                  fault;
  logic [CNT_W-1:0]      load_count;

  modport master (
    output load_en, load_we, load_addr, load_data,
    output fetch_req, fetch_addr, stall,
    input  instruction, inst_valid, fault, load_count
  );

  modport slave (
    input  load_en, load_we, load_addr, load_data,
    input  fetch_req, fetch_addr, stall,
    output instruction, inst_valid, fault, load_count
  );
endinterface

// File: rtl/imem_fetch.sv
// Synchronous-read instruction memory with a program-load mode, a fetch
// handshake with stall/hold, and a fault flag for out-of-range or misaligned
// fetches. Sits between the PC register and the decode stage.
module imem_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_ADDR  = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  imem_fetch_if.slave   bus
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = IDX_W + 1;
  // Number of byte-offset bits stripped from an address; zero in word mode.
  localparam int OFF_BITS = (BYTE_ADDR != 0) ? $clog2(DATA_WIDTH / 8) : 0;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((32'd1 << OFF_BITS) - 32'd1);
  // One extra bit so the range compare sees the whole address untruncated.
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } mode_e;

  // True when the address is word-aligned and its word index lies inside the
  // array. Every address bit takes part, so high bits never wrap into range.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ((a & OFF_MASK) == {ADDR_WIDTH{1'b0}}) &&
           ({1'b0, (a >> OFF_BITS)} < DEPTH_LIM);
  endfunction

  // Word index of an address; only meaningful when addr_ok() holds.
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF_BITS);
  endfunction

  // Storage is zero-filled at time 0 and deliberately untouched by reset so a
  // loaded program survives a core reset.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: {DATA_WIDTH{1'b0}}};

  mode_e                 state_r;
  logic [DATA_WIDTH-1:0] instruction_r;
  logic                  inst_valid_r;
  logic                  fault_r;
  logic [CNT_W-1:0]      load_count_r;

  logic                  fetch_ok_s;
  logic                  load_ok_s;
  logic                  write_en_s;
  logic                  fetch_take_s;
  logic [DATA_WIDTH-1:0] fetch_word_s;

  // Decode the current-state write/fetch qualifiers and the word to return.
  always_comb begin
    fetch_ok_s   = addr_ok(bus.fetch_addr);
    load_ok_s    = addr_ok(bus.load_addr);
    // Mode decisions use the registered state, so the entry edge still
    // fetches and the exit edge still writes.
    write_en_s   = (state_r == ST_LOAD) && bus.load_we && load_ok_s;
    fetch_take_s = (state_r == ST_RUN) && bus.fetch_req && !bus.stall;
    if (fetch_ok_s) begin
      fetch_word_s = mem_r[idx_of(bus.fetch_addr)];
    end else begin
      // Faulting fetches return an all-zero word, which decodes as NOP.
      fetch_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Program-load write port; writes and fetches never share an edge.
  always_ff @(posedge clock) begin
    if (write_en_s) begin
      mem_r[idx_of(bus.load_addr)] <= bus.load_data;
    end
  end

  // Mode FSM with the registered fetch outputs and the load counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_RUN;
      instruction_r <= {DATA_WIDTH{1'b0}};
      inst_valid_r  <= 1'b0;
      fault_r       <= 1'b0;
      load_count_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (fetch_take_s) begin
            instruction_r <= fetch_word_s;
          end
          if (bus.load_en) begin
            // Entering LOAD wins over any fetch or stall: the flags clear,
            // while the instruction word keeps whatever this edge gave it.
            state_r      <= ST_LOAD;
            load_count_r <= {CNT_W{1'b0}};
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
          end else if (!bus.stall) begin
            inst_valid_r <= bus.fetch_req;
            fault_r      <= bus.fetch_req && !fetch_ok_s;
          end
          // stall with no load entry: every output holds
        end

        ST_LOAD: begin
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b0;
          if (write_en_s && (load_count_r != CNT_MAX)) begin
            load_count_r <= load_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (!bus.load_en) begin
            state_r <= ST_RUN;
          end
        end

        default: begin
          state_r      <= ST_RUN;
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction = instruction_r;
  assign bus.inst_valid  = inst_valid_r;
  assign bus.fault       = fault_r;
  assign bus.load_count  = load_count_r;

endmodule
